// File: rtl/arbitro_mux_pkg.sv
// Shared constants for the lane-distribution transmit arbiter and its demux partner.
package arbitro_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_STALL  = 2'd2
    } state_t;

    // Bit of each forwarded word that carries the source FIFO index.
    localparam int IDX_BIT = 4;

endpackage

// File: rtl/arbitro_mux_rr_grant2.sv
// Two-input round-robin grant: one-hot grant, alternates under contention.
module rr_grant2 (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic [1:0] req,
    output logic [1:0] grant
);

    logic last_grant_q;
    logic last_grant_d;

    always_comb begin
        // NOTE: default first so no path through the block leaves grant unassigned (no latch).
        grant = 2'b00;
        if (en) begin
            case (req)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
                default: grant = 2'b00;
            endcase
        end
    end

    assign last_grant_d = grant[1] ? 1'b1 : (grant[0] ? 1'b0 : last_grant_q);

    // Resets to 1 so the first contention after reset goes to FIFO 0.
    always_ff @(posedge clk) begin
        if (reset) last_grant_q <= 1'b1;
        else       last_grant_q <= last_grant_d;
    end

endmodule

// File: rtl/arbitro_mux.sv
// Drains two show-ahead FIFOs into one tagged word stream, round-robin, honouring almost_full.
module arbitro_mux
    import arbitro_mux_pkg::*;
#(
    parameter int BW    = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [BW-1:0]    fifo0_data,
    input  logic             fifo0_empty,
    input  logic [BW-1:0]    fifo1_data,
    input  logic             fifo1_empty,
    input  logic             almost_full,
    output logic             pop0,
    output logic             pop1,
    output logic [BW-1:0]    mux_arbitro_1,
    output logic             push,
    output logic [CNT_W-1:0] cnt0,
    output logic [CNT_W-1:0] cnt1,
    output logic [1:0]       state
);

    state_t           state_q, state_d;
    logic [BW-1:0]    word_q, word_d;
    logic             push_q;
    logic [CNT_W-1:0] cnt0_q, cnt1_q;
    logic [1:0]       grant;

    rr_grant2 u_rr_grant2 (
        .clk   (clk),
        .reset (reset),
        .en    (~almost_full & ~reset),
        .req   ({~fifo1_empty, ~fifo0_empty}),
        .grant (grant)
    );

    always_comb begin
        state_d = ST_IDLE;
        if (almost_full)                      state_d = ST_STALL;
        else if (!fifo0_empty || !fifo1_empty) state_d = ST_ACTIVE;

        // Tag the word with its source so the demux can route it back.
        word_d          = grant[1] ? fifo1_data : fifo0_data;
        word_d[IDX_BIT] = grant[1];
    end

    always_ff @(posedge clk) begin
        // NOTE: every register here has a defined reset value; non-blocking assignments only.
        if (reset) begin
            state_q <= ST_IDLE;
            word_q  <= '0;
            push_q  <= 1'b0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
        end else begin
            state_q <= state_d;
            push_q  <= |grant;
            if (|grant) word_q <= word_d;
            if (grant[0]) cnt0_q <= cnt0_q + CNT_W'(1);
            if (grant[1]) cnt1_q <= cnt1_q + CNT_W'(1);
        end
    end

    assign pop0          = grant[0];
    assign pop1          = grant[1];
    assign mux_arbitro_1 = word_q;
    assign push          = push_q;
    assign cnt0          = cnt0_q;
    assign cnt1          = cnt1_q;
    assign state         = state_q;

endmodule

// File: tb/tb_arbitro_mux.sv
// Directed bench for arbitro_mux: FIFOs modelled as queues, expectations hand-computed.
module tb_arbitro_mux;

    logic       clk;
    logic       reset;
    logic [5:0] fifo0_data, fifo1_data;
    logic       fifo0_empty, fifo1_empty;
    logic       almost_full;
    logic       pop0, pop1;
    logic [5:0] mux_arbitro_1;
    logic       push;
    logic [7:0] cnt0, cnt1;
    logic [1:0] state;

    int total = 0;
    int bad   = 0;

    logic [5:0] q0[$];
    logic [5:0] q1[$];
    logic       s_pop0, s_pop1, s_push;

    arbitro_mux #(.BW(6), .CNT_W(8)) dut (
        .clk           (clk),
        .reset         (reset),
        .fifo0_data    (fifo0_data),
        .fifo0_empty   (fifo0_empty),
        .fifo1_data    (fifo1_data),
        .fifo1_empty   (fifo1_empty),
        .almost_full   (almost_full),
        .pop0          (pop0),
        .pop1          (pop1),
        .mux_arbitro_1 (mux_arbitro_1),
        .push          (push),
        .cnt0          (cnt0),
        .cnt1          (cnt1),
        .state         (state)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock cycle: present FIFO heads, sample pops/push mid-cycle, pop the queues at the edge,
    // then return 1 time unit after the edge with registered outputs settled.
    task automatic tick();
        fifo0_empty = (q0.size() == 0);
        fifo1_empty = (q1.size() == 0);
        fifo0_data  = (q0.size() != 0) ? q0[0] : 6'h00;
        fifo1_data  = (q1.size() != 0) ? q1[0] : 6'h00;
        #1;
        s_pop0 = pop0;
        s_pop1 = pop1;
        s_push = push;
        @(posedge clk);
        if (s_pop0 && q0.size() != 0) void'(q0.pop_front());
        if (s_pop1 && q1.size() != 0) void'(q1.pop_front());
        #1;
    endtask

    task automatic do_reset();
        q0.delete();
        q1.delete();
        almost_full = 1'b0;
        reset = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        q0.delete();
        q1.delete();
        q0.push_back(6'h05);
        q1.push_back(6'h06);
        almost_full = 1'b0;
        reset = 1'b1;
        tick();
        total++;
        if ({s_pop0, s_pop1} !== 2'b00) begin
            bad++;
            $display("FAIL reset_pop: got %b want 00", {s_pop0, s_pop1});
        end
        total++;
        if ({push, mux_arbitro_1, cnt0, cnt1, state} !== {1'b0, 6'h00, 8'h00, 8'h00, 2'd0}) begin
            bad++;
            $display("FAIL reset_regs: push=%b mux=%h cnt0=%0d cnt1=%0d state=%0d want all 0",
                     push, mux_arbitro_1, cnt0, cnt1, state);
        end
        reset = 1'b0;
    endtask

    task automatic test_single_source();
        logic [5:0] exp_w[3] = '{6'h0F, 6'h2A, 6'h01};
        do_reset();
        q0.push_back(6'h0F);
        q0.push_back(6'h2A);
        q0.push_back(6'h11);
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({s_pop0, s_pop1, push, mux_arbitro_1, state} !== {2'b10, 1'b1, exp_w[i], 2'd1}) begin
                bad++;
                $display("FAIL single_word%0d: pop=%b%b push=%b mux=%h state=%0d want pop=10 push=1 mux=%h state=1",
                         i, s_pop0, s_pop1, push, mux_arbitro_1, state, exp_w[i]);
            end
        end
        tick();
        total++;
        if ({s_pop0, push, mux_arbitro_1, cnt0, state} !== {1'b0, 1'b0, 6'h01, 8'd3, 2'd0}) begin
            bad++;
            $display("FAIL single_end: pop0=%b push=%b mux=%h cnt0=%0d state=%0d want 0 0 01 3 0",
                     s_pop0, push, mux_arbitro_1, cnt0, state);
        end
    endtask

    task automatic test_contention();
        logic [1:0] exp_pop[8] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01, 2'b10, 2'b01};
        logic [5:0] exp_w[8]   = '{6'h00, 6'h15, 6'h01, 6'h1A, 6'h02, 6'h33, 6'h03, 6'h3C};
        do_reset();
        q0 = '{6'h00, 6'h01, 6'h02, 6'h03};
        q1 = '{6'h05, 6'h0A, 6'h23, 6'h3C};
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if ({s_pop0, s_pop1, push, mux_arbitro_1} !== {exp_pop[i], 1'b1, exp_w[i]}) begin
                bad++;
                $display("FAIL contend_%0d: pop=%b%b push=%b mux=%h want pop=%b push=1 mux=%h",
                         i, s_pop0, s_pop1, push, mux_arbitro_1, exp_pop[i], exp_w[i]);
            end
        end
        tick();
        total++;
        if ({push, cnt0, cnt1, state} !== {1'b0, 8'd4, 8'd4, 2'd0}) begin
            bad++;
            $display("FAIL contend_end: push=%b cnt0=%0d cnt1=%0d state=%0d want 0 4 4 0",
                     push, cnt0, cnt1, state);
        end
    endtask

    task automatic test_stall();
        do_reset();
        q0 = '{6'h01, 6'h02, 6'h03};
        q1 = '{6'h04, 6'h05};
        tick();
        tick();
        total++;
        if ({s_pop1, push, mux_arbitro_1} !== {1'b1, 1'b1, 6'h14}) begin
            bad++;
            $display("FAIL stall_pre: pop1=%b push=%b mux=%h want 1 1 14", s_pop1, push, mux_arbitro_1);
        end
        almost_full = 1'b1;
        tick();
        total++;
        if ({s_pop0, s_pop1, s_push} !== 3'b001) begin
            bad++;
            $display("FAIL stall_block: pop=%b%b push_in_cycle=%b want pop=00 push=1", s_pop0, s_pop1, s_push);
        end
        total++;
        if ({push, mux_arbitro_1, state} !== {1'b0, 6'h14, 2'd2}) begin
            bad++;
            $display("FAIL stall_state: push=%b mux=%h state=%0d want 0 14 2", push, mux_arbitro_1, state);
        end
        tick();
        total++;
        if ({s_pop0, s_pop1, push, state, cnt0, cnt1} !== {2'b00, 1'b0, 2'd2, 8'd1, 8'd1}) begin
            bad++;
            $display("FAIL stall_hold: pop=%b%b push=%b state=%0d cnt0=%0d cnt1=%0d want 00 0 2 1 1",
                     s_pop0, s_pop1, push, state, cnt0, cnt1);
        end
        almost_full = 1'b0;
        tick();
        total++;
        if ({s_pop0, s_pop1, push, mux_arbitro_1, state} !== {2'b10, 1'b1, 6'h02, 2'd1}) begin
            bad++;
            $display("FAIL stall_resume: pop=%b%b push=%b mux=%h state=%0d want 10 1 02 1",
                     s_pop0, s_pop1, push, mux_arbitro_1, state);
        end
        tick();
        total++;
        if ({s_pop1, mux_arbitro_1} !== {1'b1, 6'h15}) begin
            bad++;
            $display("FAIL stall_resume2: pop1=%b mux=%h want 1 15", s_pop1, mux_arbitro_1);
        end
        tick();
        total++;
        if ({s_pop0, mux_arbitro_1, cnt0, cnt1} !== {1'b1, 6'h03, 8'd3, 8'd2}) begin
            bad++;
            $display("FAIL stall_drain: pop0=%b mux=%h cnt0=%0d cnt1=%0d want 1 03 3 2",
                     s_pop0, mux_arbitro_1, cnt0, cnt1);
        end
    endtask

    task automatic test_reset_mid_stream();
        do_reset();
        q0 = '{6'h07, 6'h08, 6'h09};
        q1 = '{6'h0B, 6'h0C};
        tick();
        reset = 1'b1;
        tick();
        total++;
        if ({s_pop0, s_pop1} !== 2'b00) begin
            bad++;
            $display("FAIL midreset_pop: pop=%b%b want 00", s_pop0, s_pop1);
        end
        total++;
        if ({push, mux_arbitro_1, cnt0, cnt1, state} !== {1'b0, 6'h00, 8'd0, 8'd0, 2'd0}) begin
            bad++;
            $display("FAIL midreset_regs: push=%b mux=%h cnt0=%0d cnt1=%0d state=%0d want all 0",
                     push, mux_arbitro_1, cnt0, cnt1, state);
        end
        reset = 1'b0;
        tick();
        total++;
        if ({s_pop0, s_pop1, push, mux_arbitro_1} !== {2'b10, 1'b1, 6'h08}) begin
            bad++;
            $display("FAIL midreset_first: pop=%b%b push=%b mux=%h want 10 1 08",
                     s_pop0, s_pop1, push, mux_arbitro_1);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int i = 0; i < 256; i++) q1.push_back(6'(i));
        for (int i = 0; i < 256; i++) begin
            tick();
            total++;
            if ({s_pop1, push, mux_arbitro_1, cnt1} !== {1'b1, 1'b1, 6'(i) | 6'h10, 8'(i + 1)}) begin
                bad++;
                $display("FAIL wrap_%0d: pop1=%b push=%b mux=%h cnt1=%0d want 1 1 %h %0d",
                         i, s_pop1, push, mux_arbitro_1, cnt1, 6'(i) | 6'h10, (i + 1) % 256);
            end
        end
        total++;
        if ({cnt0, cnt1} !== {8'd0, 8'd0}) begin
            bad++;
            $display("FAIL wrap_end: cnt0=%0d cnt1=%0d want 0 0", cnt0, cnt1);
        end
    endtask

    initial begin
        reset       = 1'b1;
        almost_full = 1'b0;
        fifo0_data  = '0;
        fifo1_data  = '0;
        fifo0_empty = 1'b1;
        fifo1_empty = 1'b1;
        test_reset();
        test_single_source();
        test_contention();
        test_stall();
        test_reset_mid_stream();
        test_counter_wrap();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
